// File: rtl/osd_trace_packetize.sv
// osd_trace_packetize
// Serialises one trace sample (or overflow record) into a debug event packet
// of 16-bit flits: destination, source, type header, then the payload words.
// A sample is captured on accept and held until the whole packet has drained.
// While a packet is in flight the sample stage is held off.

module osd_trace_packetize #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      id,
    input  logic [15:0]      event_dest,
    input  logic [WIDTH-1:0] trace_data,
    input  logic             trace_overflow,
    input  logic             trace_valid,
    output logic             trace_ready,
    output logic [15:0]      debug_out_data,
    output logic             debug_out_last,
    output logic             debug_out_valid,
    input  logic             debug_out_ready
);

    localparam int NUM_WORDS = (WIDTH + 15) / 16;
    localparam int WCNT_W    = ($clog2(NUM_WORDS + 1) > 1) ? $clog2(NUM_WORDS + 1) : 1;
    localparam int PAD_W     = NUM_WORDS * 16;

    typedef enum logic [2:0] {
        IDLE,
        DEST,
        SRC,
        TYPE,
        PAYLOAD
    } state_t;

    state_t             state;
    logic [WCNT_W-1:0]  wcnt;
    logic [WIDTH-1:0]   hold_data;
    logic               hold_ovf;

    logic               flit_fire;
    logic [WCNT_W-1:0]  next_wcnt;
    logic [15:0]        next_word;
    logic               next_last;

    assign flit_fire = debug_out_valid & debug_out_ready;

    // Payload word that will be presented after the current flit is consumed.
    always_comb begin
        next_wcnt = (state == PAYLOAD) ? wcnt + WCNT_W'(1) : '0;
        // Zero-extend to whole words, then shift the wanted word to the bottom.
        next_word = 16'(PAD_W'(hold_data) >> {next_wcnt, 4'b0000});
        next_last = 1'b0;
        if (hold_ovf) begin
            // An overflow record carries only its 10-bit count, in one flit.
            next_word = {6'b0, hold_data[9:0]};
            next_last = 1'b1;
        end else begin
            next_last = (next_wcnt == WCNT_W'(NUM_WORDS - 1));
        end
    end

    // Packet FSM with registered flit outputs; each step waits for a flit handshake.
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the holding registers are plain flops, not a memory, so they
            // are reset along with the FSM and start from a known zero.
            state           <= IDLE;
            wcnt            <= '0;
            hold_data       <= '0;
            hold_ovf        <= 1'b0;
            trace_ready     <= 1'b1;
            debug_out_valid <= 1'b0;
            debug_out_last  <= 1'b0;
            debug_out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trace_valid) begin
                        hold_data       <= trace_data;
                        hold_ovf        <= trace_overflow;
                        // The destination flit register doubles as the
                        // destination holding register for this packet.
                        debug_out_data  <= event_dest;
                        debug_out_last  <= 1'b0;
                        debug_out_valid <= 1'b1;
                        trace_ready     <= 1'b0;
                        state           <= DEST;
                    end
                end
                DEST: begin
                    if (flit_fire) begin
                        debug_out_data <= id;
                        state          <= SRC;
                    end
                end
                SRC: begin
                    if (flit_fire) begin
                        debug_out_data <= {2'b10, (hold_ovf ? 4'h1 : 4'h0), 10'b0};
                        state          <= TYPE;
                    end
                end
                TYPE: begin
                    if (flit_fire) begin
                        wcnt           <= next_wcnt;
                        debug_out_data <= next_word;
                        debug_out_last <= next_last;
                        state          <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (flit_fire) begin
                        if (debug_out_last) begin
                            wcnt            <= '0;
                            debug_out_data  <= '0;
                            debug_out_last  <= 1'b0;
                            debug_out_valid <= 1'b0;
                            trace_ready     <= 1'b1;
                            state           <= IDLE;
                        end else begin
                            wcnt           <= next_wcnt;
                            debug_out_data <= next_word;
                            debug_out_last <= next_last;
                        end
                    end
                end
                default: begin
                    state           <= IDLE;
                    debug_out_valid <= 1'b0;
                    debug_out_last  <= 1'b0;
                    trace_ready     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osd_trace_packetize.sv
// Self-checking bench for osd_trace_packetize.
// Three instances (WIDTH 16, 40, 32) share clock and reset; a table of packet
// vectors is driven through them, followed by hand-written sequences for
// mid-packet reset and back-to-back samples.

module tb_osd_trace_packetize;

    logic clk;
    logic rst_n;

    // Per-instance signals: 0 -> WIDTH=16, 1 -> WIDTH=40, 2 -> WIDTH=32
    logic [15:0] id_s     [3];
    logic [15:0] dest_s   [3];
    logic [39:0] tdata_s  [3];
    logic        tovf     [3];
    logic        tvalid   [3];
    logic        tready   [3];
    logic [15:0] ddata    [3];
    logic        dlast    [3];
    logic        dvalid   [3];
    logic        dready   [3];

    int n_tests = 0;
    int n_fail  = 0;

    osd_trace_packetize #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .id(id_s[0]), .event_dest(dest_s[0]),
        .trace_data(tdata_s[0][15:0]), .trace_overflow(tovf[0]),
        .trace_valid(tvalid[0]), .trace_ready(tready[0]),
        .debug_out_data(ddata[0]), .debug_out_last(dlast[0]),
        .debug_out_valid(dvalid[0]), .debug_out_ready(dready[0])
    );

    osd_trace_packetize #(.WIDTH(40)) u_w40 (
        .clk(clk), .rst_n(rst_n), .id(id_s[1]), .event_dest(dest_s[1]),
        .trace_data(tdata_s[1]), .trace_overflow(tovf[1]),
        .trace_valid(tvalid[1]), .trace_ready(tready[1]),
        .debug_out_data(ddata[1]), .debug_out_last(dlast[1]),
        .debug_out_valid(dvalid[1]), .debug_out_ready(dready[1])
    );

    osd_trace_packetize #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .id(id_s[2]), .event_dest(dest_s[2]),
        .trace_data(tdata_s[2][31:0]), .trace_overflow(tovf[2]),
        .trace_valid(tvalid[2]), .trace_ready(tready[2]),
        .debug_out_data(ddata[2]), .debug_out_last(dlast[2]),
        .debug_out_valid(dvalid[2]), .debug_out_ready(dready[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          unit;
        logic [39:0] data;
        logic        ovf;
        logic [15:0] dest;
        bit          bp;      // random debug_out_ready plus input churn mid-packet
        int          nflits;
        logic [15:0] flit [6];
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one sample into a unit and collect/verify its packet.
    task automatic run_vector(input int idx, input vec_t v);
        int          u;
        int          got;
        int          cyc;
        bit          done;
        bit          stalled;
        bit          rdy;
        logic [15:0] prev_d;
        logic        prev_l;
        u       = v.unit;
        got     = 0;
        cyc     = 0;
        done    = 1'b0;
        stalled = 1'b0;
        prev_d  = '0;
        prev_l  = 1'b0;

        @(negedge clk);
        check($sformatf("v%0d idle_trace_ready", idx), 64'(tready[u]), 64'd1);
        check($sformatf("v%0d idle_valid", idx), 64'(dvalid[u]), 64'd0);
        tdata_s[u] = v.data;
        tovf[u]    = v.ovf;
        dest_s[u]  = v.dest;
        tvalid[u]  = 1'b1;
        dready[u]  = 1'b0;
        @(negedge clk);
        tvalid[u] = 1'b0;
        check($sformatf("v%0d dest_latency", idx), 64'(dvalid[u]), 64'd1);

        while (!done && cyc < 200) begin
            rdy = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v.bp) begin
                tdata_s[u] = {8'($urandom), 32'($urandom)};
                dest_s[u]  = 16'($urandom);
                tovf[u]    = ~v.ovf;
            end
            check($sformatf("v%0d valid_held c%0d", idx, cyc), 64'(dvalid[u]), 64'd1);
            check($sformatf("v%0d trace_ready_low c%0d", idx, cyc), 64'(tready[u]), 64'd0);
            if (stalled) begin
                check($sformatf("v%0d stall_data c%0d", idx, cyc), 64'(ddata[u]), 64'(prev_d));
                check($sformatf("v%0d stall_last c%0d", idx, cyc), 64'(dlast[u]), 64'(prev_l));
            end
            dready[u] = rdy;
            if (rdy) begin
                if (got < 6) begin
                    check($sformatf("v%0d flit%0d_data", idx, got), 64'(ddata[u]),
                          (got < v.nflits) ? 64'(v.flit[got]) : 64'hDEAD);
                    check($sformatf("v%0d flit%0d_last", idx, got), 64'(dlast[u]),
                          64'(got == v.nflits - 1));
                end
                if (dlast[u] || got >= 6) done = 1'b1;
                got++;
            end
            stalled = !rdy;
            prev_d  = ddata[u];
            prev_l  = dlast[u];
            cyc++;
            @(negedge clk);
        end
        dready[u] = 1'b0;
        check($sformatf("v%0d completed", idx), 64'(done), 64'd1);
        check($sformatf("v%0d flit_count", idx), 64'(got), 64'(v.nflits));
        if (!v.bp)
            check($sformatf("v%0d packet_cycles", idx), 64'(cyc), 64'(v.nflits));
        check($sformatf("v%0d back_to_idle_ready", idx), 64'(tready[u]), 64'd1);
        check($sformatf("v%0d back_to_idle_valid", idx), 64'(dvalid[u]), 64'd0);
        tovf[u] = 1'b0;
    endtask

    initial begin
        int          acc;
        int          pkts;
        int          acc_cyc [4];
        logic [15:0] samples [4];
        logic [15:0] payload [4];

        // Vector table: hand-computed flit sequences.
        vecs[0] = '{unit:0, data:40'hABCD, ovf:1'b0, dest:16'h0000, bp:1'b0, nflits:4,
                    flit:'{16'h0000, 16'h0005, 16'h8000, 16'hABCD, 16'h0, 16'h0}};
        vecs[1] = '{unit:1, data:40'h12_3456_789A, ovf:1'b0, dest:16'h1234, bp:1'b0, nflits:6,
                    flit:'{16'h1234, 16'h00A1, 16'h8000, 16'h789A, 16'h3456, 16'h0012}};
        vecs[2] = '{unit:2, data:40'hFFFF_03FF, ovf:1'b1, dest:16'h0BEE, bp:1'b0, nflits:4,
                    flit:'{16'h0BEE, 16'h0032, 16'h8400, 16'h03FF, 16'h0, 16'h0}};
        vecs[3] = '{unit:1, data:40'hFE_DCBA_9876, ovf:1'b0, dest:16'h4321, bp:1'b1, nflits:6,
                    flit:'{16'h4321, 16'h00A1, 16'h8000, 16'h9876, 16'hDCBA, 16'h00FE}};
        vecs[4] = '{unit:0, data:40'hFC05, ovf:1'b1, dest:16'h7777, bp:1'b0, nflits:4,
                    flit:'{16'h7777, 16'h0005, 16'h8400, 16'h0005, 16'h0, 16'h0}};
        vecs[5] = '{unit:2, data:40'hCAFE_F00D, ovf:1'b0, dest:16'h00FF, bp:1'b1, nflits:5,
                    flit:'{16'h00FF, 16'h0032, 16'h8000, 16'hF00D, 16'hCAFE, 16'h0}};
        vecs[6] = '{unit:1, data:40'hFF_FFFF_FFFF, ovf:1'b1, dest:16'h0001, bp:1'b0, nflits:4,
                    flit:'{16'h0001, 16'h00A1, 16'h8400, 16'h03FF, 16'h0, 16'h0}};
        vecs[7] = '{unit:2, data:40'h0000_0200, ovf:1'b1, dest:16'hABAB, bp:1'b1, nflits:4,
                    flit:'{16'hABAB, 16'h0032, 16'h8400, 16'h0200, 16'h0, 16'h0}};

        id_s[0] = 16'h0005;
        id_s[1] = 16'h00A1;
        id_s[2] = 16'h0032;
        for (int u = 0; u < 3; u++) begin
            dest_s[u]  = '0;
            tdata_s[u] = '0;
            tovf[u]    = 1'b0;
            tvalid[u]  = 1'b0;
            dready[u]  = 1'b0;
        end

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check($sformatf("u%0d reset trace_ready", u), 64'(tready[u]), 64'd1);
            check($sformatf("u%0d reset valid", u), 64'(dvalid[u]), 64'd0);
            check($sformatf("u%0d reset last", u), 64'(dlast[u]), 64'd0);
            check($sformatf("u%0d reset data", u), 64'(ddata[u]), 64'd0);
        end
        rst_n = 1'b1;

        // Table-driven packets
        for (int i = 0; i < 8; i++) run_vector(i, vecs[i]);

        // Async reset during the SRC flit of a WIDTH=40 packet
        @(negedge clk);
        tdata_s[1] = 40'h55_6677_8899;
        dest_s[1]  = 16'h0F0F;
        tvalid[1]  = 1'b1;
        @(negedge clk);
        tvalid[1] = 1'b0;
        dready[1] = 1'b1;
        @(negedge clk);
        check("rst_mid sanity src flit", 64'(ddata[1]), 64'h00A1);
        rst_n = 1'b0;
        #1;
        check("rst_mid valid", 64'(dvalid[1]), 64'd0);
        check("rst_mid data", 64'(ddata[1]), 64'd0);
        check("rst_mid last", 64'(dlast[1]), 64'd0);
        check("rst_mid trace_ready", 64'(tready[1]), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("rst_mid no_retransmit c%0d", c), 64'(dvalid[1]), 64'd0);
        end
        dready[1] = 1'b0;
        run_vector(8, vecs[1]);

        // Back-to-back samples on the WIDTH=16 unit with trace_valid held
        samples = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        acc  = 0;
        pkts = 0;
        dready[0] = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (dvalid[0] && dlast[0]) begin
                if (pkts < 4) payload[pkts] = ddata[0];
                pkts++;
            end
            if (acc < 4) begin
                tdata_s[0] = 40'(samples[acc]);
                tvalid[0]  = 1'b1;
            end else begin
                tvalid[0] = 1'b0;
            end
            if (tvalid[0] && tready[0]) begin
                acc_cyc[acc] = cyc;
                acc++;
            end
            if (acc == 4 && pkts == 4) break;
        end
        tvalid[0] = 1'b0;
        dready[0] = 1'b0;
        check("b2b samples accepted", 64'(acc), 64'd4);
        check("b2b packet count", 64'(pkts), 64'(acc));
        for (int i = 0; i < 4; i++) begin
            if (i < pkts && i < acc)
                check($sformatf("b2b payload%0d", i), 64'(payload[i]), 64'(samples[i]));
            if (i > 0 && i < acc)
                check($sformatf("b2b interval%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd5);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
